// File: rtl/cpu_bus_ctrl_pkg.sv
// Shared encodings for the CPU bus transaction engine: FSM states and access-size codes.
package cpu_bus_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/cpu_bus_ctrl_if.sv
// Core request/response port plus peripheral bus pins; names are from the controller's view.
interface cpu_bus_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  i_req_valid;
  logic                  o_req_ready;
  logic                  i_req_we;
  logic [1:0]            i_req_size;
  logic                  i_req_sext;
  logic [ADDR_W-1:0]     i_req_addr;
  logic [DATA_W-1:0]     i_req_wdata;
  logic                  o_rsp_valid;
  logic [DATA_W-1:0]     o_rsp_rdata;
  logic                  o_rsp_err;
  logic                  o_wr_err;
  logic                  i_clr_err;
  logic                  o_bus_clk;
  logic                  o_bus_we;
  logic [DATA_W/8-1:0]   o_bus_be;
  logic [ADDR_W-1:0]     o_bus_addr;
  logic [DATA_W-1:0]     o_bus_data;
  logic [DATA_W-1:0]     i_bus_data;
  logic                  i_bus_data_ready;

  // Controller side
  modport slave (
    input  i_req_valid, i_req_we, i_req_size, i_req_sext, i_req_addr, i_req_wdata,
    input  i_clr_err, i_bus_data, i_bus_data_ready,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_wr_err,
    output o_bus_clk, o_bus_we, o_bus_be, o_bus_addr, o_bus_data
  );

  // Core and peripheral side
  modport master (
    output i_req_valid, i_req_we, i_req_size, i_req_sext, i_req_addr, i_req_wdata,
    output i_clr_err, i_bus_data, i_bus_data_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_wr_err,
    input  o_bus_clk, o_bus_we, o_bus_be, o_bus_addr, o_bus_data
  );
endinterface

// File: rtl/cpu_bus_ctrl_lane.sv
// Combinational lane steering: byte enables and write shift, read extract and extension.
module cpu_bus_ctrl_lane
  import cpu_bus_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int NB    = DATA_W / 8,
  localparam int LB    = $clog2(NB)
) (
  input  logic [1:0]        size_i,
  input  logic              sext_i,
  input  logic [LB-1:0]     offs_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [NB-1:0]     be_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [DATA_W-1:0] rdata_o
);

  logic [LB-1:0]     lane;
  logic [NB-1:0]     mask;
  logic [DATA_W-1:0] shifted;

  always_comb begin
    lane    = offs_i;
    mask    = '1;
    shifted = '0;
    be_o    = '0;
    wdata_o = '0;
    rdata_o = '0;

    // Misaligned accesses are aligned down to the natural boundary of their size
    case (size_i)
      SIZE_BYTE: mask = NB'(1);
      SIZE_HALF: begin
        mask    = NB'(3);
        lane[0] = 1'b0;
      end
      default: begin
        mask = '1;
        lane = '0;
      end
    endcase

    be_o    = mask << lane;
    wdata_o = wdata_i << {lane, 3'b000};
    shifted = rdata_i >> {lane, 3'b000};

    case (size_i)
      SIZE_BYTE: rdata_o = {{(DATA_W-8){sext_i & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: rdata_o = {{(DATA_W-16){sext_i & shifted[15]}}, shifted[15:0]};
      default:   rdata_o = shifted;
    endcase
  end

endmodule

// File: rtl/cpu_bus_ctrl.sv
// Bus transaction engine: IDLE->SETUP->STROBE->WAIT->DONE with sized lanes, posted writes
// and a wait-state timeout. Bus strobe is decoded from the async-reset state register.
module cpu_bus_ctrl
  import cpu_bus_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STROBE_LEN = 1,
  parameter int TIMEOUT    = 255,
  parameter int POSTED_WR  = 1
) (
  input  logic           i_cpu_clk,
  input  logic           i_rst_n,
  cpu_bus_ctrl_if.slave  bus
);

  localparam int NB      = DATA_W / 8;
  localparam int LB      = $clog2(NB);
  localparam int CNT_MAX = (TIMEOUT > STROBE_LEN) ? TIMEOUT : STROBE_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, sext_q, posted_q, timeout_q, wr_err_q;
  logic [1:0]         size_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q, rdata_q;

  logic               accept, bus_act, wait_expire;
  logic               rsp_valid, rsp_err;
  logic [DATA_W-1:0]  rsp_rdata;
  logic [NB-1:0]      lane_be;
  logic [DATA_W-1:0]  lane_wdata, lane_rdata;

  cpu_bus_ctrl_lane #(.DATA_W(DATA_W)) u_lane (
    .size_i  (size_q),
    .sext_i  (sext_q),
    .offs_i  (addr_q[LB-1:0]),
    .wdata_i (wdata_q),
    .rdata_i (rdata_q),
    .be_o    (lane_be),
    .wdata_o (lane_wdata),
    .rdata_o (lane_rdata)
  );

  assign accept      = bus.i_req_valid && (state_q == ST_IDLE);
  assign wait_expire = (state_q == ST_WAIT) && !bus.i_bus_data_ready &&
                       (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bus_act   = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (accept) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        bus_act   = 1'b1;
        rsp_valid = posted_q;
        cnt_d     = '0;
        state_d   = ST_STROBE;
      end
      ST_STROBE: begin
        bus_act = 1'b1;
        if (cnt_q == CNT_W'(STROBE_LEN - 1)) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT: begin
        bus_act = 1'b1;
        if (bus.i_bus_data_ready || wait_expire) state_d = ST_DONE;
        else                                     cnt_d   = cnt_q + 1'b1;
      end
      ST_DONE: begin
        rsp_valid = !posted_q;
        rsp_err   = !posted_q && timeout_q;
        rsp_rdata = (!posted_q && !we_q) ? lane_rdata : '0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_cpu_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      sext_q    <= 1'b0;
      posted_q  <= 1'b0;
      timeout_q <= 1'b0;
      wr_err_q  <= 1'b0;
      size_q    <= SIZE_BYTE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q      <= bus.i_req_we;
        sext_q    <= bus.i_req_sext;
        posted_q  <= bus.i_req_we && (POSTED_WR != 0);
        size_q    <= bus.i_req_size;
        addr_q    <= bus.i_req_addr;
        wdata_q   <= bus.i_req_wdata;
        timeout_q <= 1'b0;
      end
      if (state_q == ST_WAIT && bus.i_bus_data_ready) rdata_q <= bus.i_bus_data;
      if (wait_expire) timeout_q <= 1'b1;
      // A posted-write timeout in the same cycle as a clear keeps the flag set
      if (state_q == ST_DONE && posted_q && timeout_q) wr_err_q <= 1'b1;
      else if (bus.i_clr_err)                          wr_err_q <= 1'b0;
    end
  end

  assign bus.o_req_ready = (state_q == ST_IDLE);
  assign bus.o_rsp_valid = rsp_valid;
  assign bus.o_rsp_err   = rsp_err;
  assign bus.o_rsp_rdata = rsp_rdata;
  assign bus.o_wr_err    = wr_err_q;
  assign bus.o_bus_clk   = (state_q == ST_STROBE);
  assign bus.o_bus_we    = bus_act && we_q;
  assign bus.o_bus_be    = bus_act ? lane_be : '0;
  assign bus.o_bus_addr  = bus_act ? {addr_q[ADDR_W-1:LB], {LB{1'b0}}} : '0;
  assign bus.o_bus_data  = (bus_act && we_q) ? lane_wdata : '0;

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Directed bench for cpu_bus_ctrl (DATA_W=32, STROBE_LEN=1, TIMEOUT=8) with immediate assertions.
module tb_cpu_bus_ctrl;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;
  int   n;

  cpu_bus_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  cpu_bus_ctrl #(
    .ADDR_W(32), .DATA_W(32), .STROBE_LEN(1), .TIMEOUT(8), .POSTED_WR(1)
  ) dut (
    .i_cpu_clk (clk),
    .i_rst_n   (rst_n),
    .bus       (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present a request for one edge, then withdraw it; returns in the SETUP cycle.
  task automatic issue(input logic we, input logic [1:0] size, input logic sext,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bus_if.i_req_we    = we;
    bus_if.i_req_size  = size;
    bus_if.i_req_sext  = sext;
    bus_if.i_req_addr  = addr;
    bus_if.i_req_wdata = wdata;
    bus_if.i_req_valid = 1'b1;
    tick();
    bus_if.i_req_valid = 1'b0;
  endtask

  // Cycles from acceptance edge to response; the SETUP cycle counts as 1.
  task automatic wait_rsp(input int max, output int cyc);
    cyc = 1;
    while (!bus_if.o_rsp_valid && cyc < max) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n                   = 1'b0;
    bus_if.i_req_valid      = 1'b0;
    bus_if.i_req_we         = 1'b0;
    bus_if.i_req_size       = 2'd0;
    bus_if.i_req_sext       = 1'b0;
    bus_if.i_req_addr       = '0;
    bus_if.i_req_wdata      = '0;
    bus_if.i_clr_err        = 1'b0;
    bus_if.i_bus_data       = '0;
    bus_if.i_bus_data_ready = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst_ready",   32'(bus_if.o_req_ready), 32'd1);
    check("rst_bus_clk", 32'(bus_if.o_bus_clk),   32'd0);
    check("rst_rsp",     32'(bus_if.o_rsp_valid), 32'd0);
    check("rst_wr_err",  32'(bus_if.o_wr_err),    32'd0);
    check("rst_be",      32'(bus_if.o_bus_be),    32'd0);
    check("rst_addr",    bus_if.o_bus_addr,       32'd0);
    rst_n = 1'b1;
    tick();

    // 1: word read, ready on first WAIT cycle
    bus_if.i_bus_data = 32'hDEADBEEF;
    issue(1'b0, 2'd2, 1'b0, 32'h0000_1000, 32'h0);
    check("t1_setup_addr", bus_if.o_bus_addr,       32'h0000_1000);
    check("t1_setup_be",   32'(bus_if.o_bus_be),    32'hF);
    check("t1_setup_clk",  32'(bus_if.o_bus_clk),   32'd0);
    check("t1_setup_rdy",  32'(bus_if.o_req_ready), 32'd0);
    tick();
    check("t1_strobe_clk", 32'(bus_if.o_bus_clk),   32'd1);
    check("t1_strobe_we",  32'(bus_if.o_bus_we),    32'd0);
    tick();
    check("t1_wait_clk",   32'(bus_if.o_bus_clk),   32'd0);
    check("t1_wait_rsp",   32'(bus_if.o_rsp_valid), 32'd0);
    tick();
    check("t1_done_rsp",   32'(bus_if.o_rsp_valid), 32'd1);
    check("t1_rdata",      bus_if.o_rsp_rdata,      32'hDEADBEEF);
    check("t1_err",        32'(bus_if.o_rsp_err),   32'd0);
    check("t1_done_be",    32'(bus_if.o_bus_be),    32'd0);
    check("t1_done_addr",  bus_if.o_bus_addr,       32'd0);
    tick();
    check("t1_idle_rdy",   32'(bus_if.o_req_ready), 32'd1);
    check("t1_idle_rsp",   32'(bus_if.o_rsp_valid), 32'd0);

    // 2: byte read at lane 3, sign- then zero-extended
    bus_if.i_bus_data = 32'h8012_3456;
    issue(1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'h0);
    check("t2_addr", bus_if.o_bus_addr,    32'h0000_1000);
    check("t2_be",   32'(bus_if.o_bus_be), 32'b1000);
    wait_rsp(20, n);
    check("t2_lat",   32'(n),             32'd4);
    check("t2_sext",  bus_if.o_rsp_rdata, 32'hFFFF_FF80);
    tick();
    issue(1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'h0);
    wait_rsp(20, n);
    check("t2_zext",  bus_if.o_rsp_rdata, 32'h0000_0080);
    tick();

    // Half read misaligned at lane 1 aligns down to lane 0
    bus_if.i_bus_data = 32'h1234_F00D;
    issue(1'b0, 2'd1, 1'b1, 32'h0000_1001, 32'h0);
    check("t2h_be", 32'(bus_if.o_bus_be), 32'b0011);
    wait_rsp(20, n);
    check("t2h_rdata", bus_if.o_rsp_rdata, 32'hFFFF_F00D);
    tick();

    // Reserved size behaves as a full word
    issue(1'b0, 2'd3, 1'b1, 32'h0000_1006, 32'h0);
    check("t2r_be",   32'(bus_if.o_bus_be), 32'hF);
    check("t2r_addr", bus_if.o_bus_addr,    32'h0000_1004);
    wait_rsp(20, n);
    check("t2r_rdata", bus_if.o_rsp_rdata, 32'h1234_F00D);
    tick();

    // 3: posted half write, response in the cycle after acceptance
    issue(1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h0000_1234);
    check("t3_rsp",   32'(bus_if.o_rsp_valid), 32'd1);
    check("t3_err",   32'(bus_if.o_rsp_err),   32'd0);
    check("t3_rdata", bus_if.o_rsp_rdata,      32'd0);
    check("t3_be",    32'(bus_if.o_bus_be),    32'b1100);
    check("t3_data",  bus_if.o_bus_data,       32'h1234_0000);
    check("t3_we",    32'(bus_if.o_bus_we),    32'd1);
    check("t3_addr",  bus_if.o_bus_addr,       32'h0000_2000);
    tick();
    check("t3_strobe_rsp",  32'(bus_if.o_rsp_valid), 32'd0);
    check("t3_strobe_data", bus_if.o_bus_data,       32'h1234_0000);
    check("t3_strobe_rdy",  32'(bus_if.o_req_ready), 32'd0);
    tick();
    check("t3_wait_rdy",  32'(bus_if.o_req_ready), 32'd0);
    tick();
    check("t3_done_rsp",  32'(bus_if.o_rsp_valid), 32'd0);
    check("t3_done_rdy",  32'(bus_if.o_req_ready), 32'd0);
    check("t3_done_we",   32'(bus_if.o_bus_we),    32'd0);
    tick();
    check("t3_idle_rdy",  32'(bus_if.o_req_ready), 32'd1);

    // 5: read stalls behind an in-flight posted write
    bus_if.i_bus_data = 32'hCAFE_F00D;
    issue(1'b1, 2'd2, 1'b0, 32'h0000_2100, 32'h5555_AAAA);
    bus_if.i_req_we    = 1'b0;
    bus_if.i_req_size  = 2'd2;
    bus_if.i_req_sext  = 1'b0;
    bus_if.i_req_addr  = 32'h0000_3000;
    bus_if.i_req_valid = 1'b1;
    check("t5_setup_rdy", 32'(bus_if.o_req_ready), 32'd0);
    tick();
    check("t5_strobe_rdy", 32'(bus_if.o_req_ready), 32'd0);
    tick();
    check("t5_wait_rdy", 32'(bus_if.o_req_ready), 32'd0);
    tick();
    check("t5_done_rdy", 32'(bus_if.o_req_ready), 32'd0);
    tick();
    check("t5_idle_rdy", 32'(bus_if.o_req_ready), 32'd1);
    tick();
    bus_if.i_req_valid = 1'b0;
    check("t5_rd_addr", bus_if.o_bus_addr,    32'h0000_3000);
    check("t5_rd_we",   32'(bus_if.o_bus_we), 32'd0);
    wait_rsp(20, n);
    check("t5_rd_lat",   32'(n),             32'd4);
    check("t5_rd_rdata", bus_if.o_rsp_rdata, 32'hCAFE_F00D);
    tick();

    // 4: read timeout after 8 WAIT cycles
    bus_if.i_bus_data_ready = 1'b0;
    issue(1'b0, 2'd2, 1'b0, 32'h0000_4000, 32'h0);
    wait_rsp(30, n);
    check("t4_rd_lat",   32'(n),                  32'd11);
    check("t4_rd_rsp",   32'(bus_if.o_rsp_valid), 32'd1);
    check("t4_rd_err",   32'(bus_if.o_rsp_err),   32'd1);
    tick();
    check("t4_rd_wrerr", 32'(bus_if.o_wr_err),    32'd0);

    // Posted write timeout sets the sticky flag, no second response
    issue(1'b1, 2'd2, 1'b0, 32'h0000_5000, 32'hA5A5_A5A5);
    check("t4_wr_rsp", 32'(bus_if.o_rsp_valid), 32'd1);
    for (int i = 0; i < 10; i++) tick();
    check("t4_wr_done_rsp",   32'(bus_if.o_rsp_valid), 32'd0);
    check("t4_wr_done_wrerr", 32'(bus_if.o_wr_err),    32'd0);
    tick();
    check("t4_wr_wrerr", 32'(bus_if.o_wr_err),    32'd1);
    check("t4_wr_rdy",   32'(bus_if.o_req_ready), 32'd1);
    tick();
    check("t4_wr_hold",  32'(bus_if.o_wr_err),    32'd1);

    // Clear held across a second write timeout: cleared mid-flight, set wins at DONE
    bus_if.i_clr_err = 1'b1;
    issue(1'b1, 2'd0, 1'b0, 32'h0000_5001, 32'h0000_00AA);
    check("t4_clr_mid", 32'(bus_if.o_wr_err), 32'd0);
    for (int i = 0; i < 11; i++) tick();
    check("t4_set_wins", 32'(bus_if.o_wr_err), 32'd1);
    tick();
    check("t4_clr_hold", 32'(bus_if.o_wr_err), 32'd0);
    bus_if.i_clr_err = 1'b0;
    bus_if.i_bus_data_ready = 1'b1;
    tick();

    // 6: reset asserted during STROBE aborts the transaction
    issue(1'b0, 2'd2, 1'b0, 32'h0000_6000, 32'h0);
    tick();
    check("t6_strobe_clk", 32'(bus_if.o_bus_clk), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_clk", 32'(bus_if.o_bus_clk),   32'd0);
    check("t6_async_rsp", 32'(bus_if.o_rsp_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    check("t6_rel_rdy",   32'(bus_if.o_req_ready), 32'd1);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus_if.o_rsp_valid) n++;
    end
    check("t6_no_rsp",  32'(n),                    32'd0);
    check("t6_rdy_end", 32'(bus_if.o_req_ready),   32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
